// File: rtl/i2c_pkg.sv
// i2c_pkg: command encodings, sequencer states and SCL quarter indices
package i2c_pkg;
  typedef enum logic [1:0] {CMD_START = 2'd0, CMD_WRITE = 2'd1, CMD_READ = 2'd2, CMD_STOP = 2'd3} cmd_t;
  typedef enum logic [3:0] {S_IDLE, S_START, S_LOAD, S_WRBIT, S_WRACK, S_RDBIT, S_RDACK, S_STOP, S_FIN} state_t;
  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;
endpackage

// File: rtl/i2c_scl_timer.sv
// i2c_scl_timer: clock divider and SCL quarter counter with sample and end-of-bit strobes
module i2c_scl_timer import i2c_pkg::*; #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  output logic [1:0] q,
  output logic       smp,
  output logic       last,
  output logic       first
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  logic [DW-1:0] div;
  logic wrap;
  assign wrap  = div == DW'(CLK_DIV - 1);
  assign smp   = wrap && q == Q2;
  assign last  = wrap && q == Q3;
  assign first = div == '0 && q == Q0;
  always_ff @(posedge clk)
    if (rst || clr) begin
      div <= '0;
      q   <= Q0;
    end else begin
      div <= wrap ? '0 : div + 1'b1;
      q   <= wrap ? q + 1'b1 : q;
    end
endmodule

// File: rtl/i2c_byte_sequencer.sv
// i2c_byte_sequencer: I2C master bit/byte sequencer driving SCL/SDA and shift-register strobes
module i2c_byte_sequencer import i2c_pkg::*; #(
  parameter int CLK_DIV = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       CmdValid,
  input  logic [1:0] Cmd,
  output logic       CmdReady,
  input  logic [7:0] TxData,
  input  logic       AckOut,
  output logic [7:0] RxData,
  output logic       AckIn,
  output logic       Done,
  output logic       SclOut,
  output logic       SdaOut,
  input  logic       SdaIn,
  output logic       LoadShift,
  output logic [7:0] ShiftRegIn,
  output logic       ShiftOut,
  output logic       ShiftIn,
  output logic       ShiftDin,
  input  logic [7:0] ShiftRegOut
);
  state_t state, nxt;
  logic [1:0] q;
  logic smp, last, first, park, ack_q, timed;
  logic [2:0] bit_cnt;
  logic [7:0] tx_q;
  assign timed = state inside {S_START, S_WRBIT, S_WRACK, S_RDBIT, S_RDACK, S_STOP};
  i2c_scl_timer #(.CLK_DIV(CLK_DIV)) u_tmr (
    .clk(Clk),
    .rst(Reset),
    .clr(!timed),
    .q(q),
    .smp(smp),
    .last(last),
    .first(first)
  );
  assign CmdReady   = state == S_IDLE && !Reset;
  assign Done       = state == S_FIN;
  assign LoadShift  = state == S_LOAD;
  assign ShiftOut   = state == S_WRBIT && last;
  assign ShiftIn    = state == S_RDBIT && smp;
  assign ShiftDin   = SdaIn;
  assign ShiftRegIn = tx_q;
  always_ff @(posedge Clk)
    if (Reset) begin
      state   <= S_IDLE;
      park    <= 1'b1;
      ack_q   <= 1'b0;
      tx_q    <= '0;
      bit_cnt <= 3'd7;
      RxData  <= '0;
      AckIn   <= 1'b1;
    end else begin
      state   <= nxt;
      park    <= nxt == S_FIN ? state == S_STOP : park;
      tx_q    <= CmdValid && CmdReady ? TxData : tx_q;
      ack_q   <= CmdValid && CmdReady ? AckOut : ack_q;
      bit_cnt <= (state == S_WRBIT || state == S_RDBIT) && last ? bit_cnt - 1'b1 : timed ? bit_cnt : 3'd7;
      AckIn   <= state == S_WRACK && smp ? SdaIn : AckIn;
      RxData  <= state == S_RDACK && first ? ShiftRegOut : RxData;
    end
  always_comb begin
    nxt    = state;
    SclOut = park;
    SdaOut = 1'b1;
    case (state)
      S_IDLE:  nxt = !CmdValid ? S_IDLE : Cmd == CMD_START ? S_START : Cmd == CMD_WRITE ? S_LOAD : Cmd == CMD_READ ? S_RDBIT : S_STOP;
      S_START: begin
        nxt    = last ? S_FIN : state;
        SclOut = q == Q0 ? park : q != Q3;
        SdaOut = q == Q0 || q == Q1;
      end
      S_LOAD:  nxt = S_WRBIT;
      S_WRBIT: begin
        nxt    = last && bit_cnt == 3'd0 ? S_WRACK : state;
        SclOut = q[1];
        SdaOut = ShiftRegOut[7];
      end
      S_WRACK: begin
        nxt    = last ? S_FIN : state;
        SclOut = q[1];
      end
      S_RDBIT: begin
        nxt    = last && bit_cnt == 3'd0 ? S_RDACK : state;
        SclOut = q[1];
      end
      S_RDACK: begin
        nxt    = last ? S_FIN : state;
        SclOut = q[1];
        SdaOut = ack_q;
      end
      S_STOP:  begin
        nxt    = last ? S_FIN : state;
        SclOut = q != Q0;
        SdaOut = q == Q2 || q == Q3;
      end
      S_FIN:   nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end
endmodule

// File: doc/i2c_byte_sequencer.md
Name: i2c_byte_sequencer

Overview:
Master-side bit/byte sequencer for the FlashI2C path. It accepts START/WRITE/READ/STOP commands from the flash-operation FSM and generates SCL. It drives SDA as open-drain and produces the LoadShift/ShiftOut/ShiftIn strobes that sequence the 8-bit shift register. The shift register holds only the data byte; all bus-level timing, ACK handling and start/stop conditions live here.

Parameters:
CLK_DIV, 4, Clk cycles per SCL quarter-period (minimum 2); one bit time = 4*CLK_DIV Clk cycles.

Ports:
Clk  input  1  system clock, all logic on rising edge
Reset  input  1  synchronous, active-high reset
CmdValid  input  1  command request
Cmd  input  2  00=START, 01=WRITE, 10=READ, 11=STOP
CmdReady  output  1  high in IDLE only; command accepted when CmdValid&CmdReady
TxData  input  8  byte for WRITE, captured at accept
AckOut  input  1  ACK bit the master sends after READ (0=ACK, 1=NACK), captured at accept
RxData  output  8  byte received by last READ
AckIn  output  1  slave ACK sampled after last WRITE (0=ACK)
Done  output  1  one-cycle pulse at command completion
SclOut  output  1  SCL level (1=released/high)
SdaOut  output  1  SDA level (1=released, 0=pull low)
SdaIn  input  1  synchronised SDA bus level
LoadShift  output  1  one-cycle pulse: shift register loads ShiftRegIn
ShiftRegIn  output  8  parallel load value (registered TxData)
ShiftOut  output  1  one-cycle pulse: shift register shifts left (MSB out)
ShiftIn  output  1  one-cycle pulse: shift register shifts in ShiftDin at LSB
ShiftDin  output  1  serial bit for ShiftIn (SdaIn sampled)
ShiftRegOut  input  8  shift register contents

Behaviour:
- Reset (synchronous, active-high): state=IDLE; SclOut=1, SdaOut=1, CmdReady=0 for the reset cycle, then 1. Done=0, LoadShift/ShiftOut/ShiftIn=0, RxData=8'h00, AckIn=1. Divider, quarter and bit counters cleared. Reset mid-command aborts immediately; the bus is released (both lines high) on the next edge.
- Timing base: a divider counts 0..CLK_DIV-1; a quarter tick q advances 0..3 on wrap. SCL is low in q0/q1 and high in q2/q3. SDA changes only at q0 entry; it is sampled at the last Clk of q2.
- States: IDLE, START, LOAD, WRBIT, WRACK, RDBIT, RDACK, STOP, FIN.
- IDLE: CmdReady=1; on accept, register TxData/AckOut, then START→START, WRITE→LOAD, READ→RDBIT, STOP→STOP. CmdValid while not IDLE is ignored (not queued).
- START (4 quarters): q0,q1 SDA=1,SCL=1; q2 SDA=0,SCL=1; q3 SDA=0,SCL=0 → FIN. This also serves as repeated start when SCL was low: q0 holds SDA=1,SCL=0, then q1 raises SCL.
- LOAD: one Clk; LoadShift=1 with ShiftRegIn=TxData → WRBIT, bit counter=7.
- WRBIT: SdaOut=ShiftRegOut[7] for the whole bit. ShiftOut pulses for one Clk on the final cycle of q3. After 8 bits → WRACK.
- WRACK: SdaOut=1 (released); AckIn<=SdaIn at the q2 sample → FIN.
- RDBIT: SdaOut=1; at the q2 sample ShiftDin=SdaIn and ShiftIn pulses for one Clk. After 8 bits → RDACK; RxData<=ShiftRegOut on the first RDACK cycle.
- RDACK: SdaOut=registered AckOut for one bit → FIN.
- STOP (4 quarters): q0 SDA=0,SCL=0; q1 SDA=0,SCL=1; q2 SDA=1,SCL=1; q3 hold → FIN.
- FIN: Done=1 for one Clk → IDLE. SCL stays at its last level: low after START/WRITE/READ, high after STOP.
- Latency, accept to Done: START/STOP 4*CLK_DIV+1; WRITE 9*4*CLK_DIV+2; READ 9*4*CLK_DIV+1.
- The strobes LoadShift, ShiftOut and ShiftIn are mutually exclusive and never asserted in the same cycle.

Decomposition:
- Shared package i2c_pkg: Cmd encodings (CMD_START/WRITE/READ/STOP), state enum, quarter indices.
- One natural sub-module: i2c_scl_timer (divider plus quarter counter, emits quarter tick and sample strobe).

Test Plan:
- CLK_DIV=4, reset then START → SDA falls while SCL=1; Done 17 Clk after accept; SclOut=0 at end.
- WRITE TxData=8'hA5, SdaIn=0 during ACK → SdaOut bit sequence 1,0,1,0,0,1,0,1; 1 LoadShift, 8 ShiftOut pulses; AckIn=0; Done at 146 Clk.
- WRITE 8'h3C with SdaIn=1 during ACK → AckIn=1 (NACK flagged); Done still pulses.
- READ, AckOut=1, SdaIn driven 0,0,1,1,1,1,0,0 per bit → 8 ShiftIn pulses; RxData=8'h3C with shift-register model; SdaOut=1 during ACK bit.
- Reset asserted at bit 3 of WRITE → next Clk SclOut=1, SdaOut=1, state IDLE, no Done; a following START completes normally.
- CmdValid pulsed with STOP during WRITE → ignored; afterwards STOP gives SDA rising while SCL=1.
